counter_sequencer: RTL

- Control stage directly upstream of the counter IC clock/reset driver.
- Takes a host request (optional clear, then step to a target position) and generates timed ADVANCE_COUNTER / RESET_COUNTER level pulses.
- Each pulse is held for PULSE_CYCLES, followed by a SETTLE_CYCLES gap, so the negative-edge counter IC sees clean, minimum-width pulses.
- Tracks the IC's count internally so the host can address absolute positions.

---
 rtl/counter_sequencer_if.sv | 37 +++
 rtl/counter_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer_if.sv
// Host <-> sequencer request/status bundle for counter_sequencer.
// Optional abort handshake present when COUNTER_SEQUENCER_ABORT_EN is defined.
interface counter_sequencer_if #(
    parameter int COUNT_W = 8
);
    logic               START;
    logic               CLEAR_FIRST;
    logic [COUNT_W-1:0] TARGET;
    logic               ADVANCE_COUNTER;
    logic               RESET_COUNTER;
    logic               BUSY;
    logic               DONE;
    logic               STEP_STROBE;
    logic [COUNT_W-1:0] POSITION;
`ifdef COUNTER_SEQUENCER_ABORT_EN
    logic               ABORT;
    logic               ABORTED;
`endif

    modport master (
        output START, CLEAR_FIRST, TARGET,
`ifdef COUNTER_SEQUENCER_ABORT_EN
        output ABORT,
        input  ABORTED,
`endif
        input  ADVANCE_COUNTER, RESET_COUNTER, BUSY, DONE, STEP_STROBE, POSITION
    );

    modport slave (
        input  START, CLEAR_FIRST, TARGET,
`ifdef COUNTER_SEQUENCER_ABORT_EN
        input  ABORT,
        output ABORTED,
`endif
        output ADVANCE_COUNTER, RESET_COUNTER, BUSY, DONE, STEP_STROBE, POSITION
    );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer: turns a host "clear, then step to TARGET" request into
// timed RESET_COUNTER / ADVANCE_COUNTER level pulses (PULSE_CYCLES high,
// SETTLE_CYCLES low) and tracks the counter IC position.
// Optional feature macro: COUNTER_SEQUENCER_ABORT_EN (adds ABORT/ABORTED).
module counter_sequencer #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 8
) (
    input logic              CLK,
    input logic              RST,
    counter_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RST_PULSE  = 3'd1;
    localparam logic [2:0] RST_SETTLE = 3'd2;
    localparam logic [2:0] ADV_PULSE  = 3'd3;
    localparam logic [2:0] ADV_SETTLE = 3'd4;
    localparam logic [2:0] FINISH     = 3'd5;

    localparam int MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
    // Timer counts down to zero, so a phase of N cycles loads N-1.
    localparam logic [TW-1:0] P_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] S_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic          STEP_ON_ENTRY = (PULSE_CYCLES == 1);

    logic [2:0]         state;
    logic [TW-1:0]      timer;
    logic [COUNT_W-1:0] target_q;
    logic [COUNT_W-1:0] position;
    logic               advance;
    logic               reset_cnt;
    logic               busy;
    logic               done;
    logic               step;
    logic               abort_flag;

`ifdef COUNTER_SEQUENCER_ABORT_EN
    logic aborted;
    logic abort_hit;
    assign abort_hit = bus.ABORT && (state != IDLE) && (state != FINISH);
    assign bus.ABORTED = aborted;
`else
    assign abort_flag = 1'b0;
`endif

    assign bus.ADVANCE_COUNTER = advance;
    assign bus.RESET_COUNTER   = reset_cnt;
    assign bus.BUSY            = busy;
    assign bus.DONE            = done;
    assign bus.STEP_STROBE     = step;
    assign bus.POSITION        = position;

    // Sequencer FSM; every output is a register updated on the transition
    // into the cycle where it must be seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            timer     <= '0;
            target_q  <= '0;
            position  <= '0;
            advance   <= 1'b0;
            reset_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step      <= 1'b0;
`ifdef COUNTER_SEQUENCER_ABORT_EN
            abort_flag <= 1'b0;
            aborted    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef COUNTER_SEQUENCER_ABORT_EN
            aborted <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        target_q <= bus.TARGET;
                        busy     <= 1'b1;
                        if (bus.CLEAR_FIRST) begin
                            state     <= RST_PULSE;
                            reset_cnt <= 1'b1;
                            timer     <= P_LD;
                        end else if (bus.TARGET != position) begin
                            state   <= ADV_PULSE;
                            advance <= 1'b1;
                            step    <= STEP_ON_ENTRY;
                            timer   <= P_LD;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                RST_PULSE: begin
                    if (timer == '0) begin
                        reset_cnt <= 1'b0;
                        position  <= '0;
                        state     <= RST_SETTLE;
                        timer     <= S_LD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RST_SETTLE: begin
                    if (timer == '0) begin
                        if (abort_flag || target_q == '0) begin
                            state <= FINISH;
                        end else begin
                            state   <= ADV_PULSE;
                            advance <= 1'b1;
                            step    <= STEP_ON_ENTRY;
                            timer   <= P_LD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ADV_PULSE: begin
                    if (timer == '0) begin
                        advance  <= 1'b0;
                        step     <= 1'b0;
                        position <= position + 1'b1;
                        state    <= ADV_SETTLE;
                        timer    <= S_LD;
                    end else begin
                        timer <= timer - 1'b1;
                        step  <= (timer == TW'(1));
                    end
                end
                ADV_SETTLE: begin
                    if (timer == '0) begin
                        if (abort_flag || position == target_q) begin
                            state <= FINISH;
                        end else begin
                            state   <= ADV_PULSE;
                            advance <= 1'b1;
                            step    <= STEP_ON_ENTRY;
                            timer   <= P_LD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef COUNTER_SEQUENCER_ABORT_EN
                    aborted    <= abort_flag;
                    abort_flag <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
`ifdef COUNTER_SEQUENCER_ABORT_EN
            // Abort drops the pulse now and runs one full settle; the case
            // above already applied any position update for a completed pulse.
            if (abort_hit) begin
                advance    <= 1'b0;
                reset_cnt  <= 1'b0;
                step       <= 1'b0;
                abort_flag <= 1'b1;
                timer      <= S_LD;
                state      <= (state == RST_PULSE || state == RST_SETTLE) ? RST_SETTLE : ADV_SETTLE;
            end
`endif
        end
    end
endmodule
